// File: rtl/rr_stream_mux_if.sv
// Handshake bundle between N_CH producer streams, the multiplexer and one consumer.
// The slave modport is the multiplexer's view; master is the surrounding environment.
interface rr_stream_mux_if #(
    parameter int N_CH = 8,
    parameter int DW   = 8
);
    localparam int CW = $clog2(N_CH);

    logic                 mode;
    logic [CW-1:0]        sel;
    logic [N_CH*DW-1:0]   in_data;
    logic [N_CH-1:0]      in_valid;
    logic [N_CH-1:0]      in_ready;
    logic [DW-1:0]        out_data;
    logic [CW-1:0]        out_ch;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/rr_stream_mux.sv
// N-channel registered stream multiplexer: fixed-select or round-robin arbitration
// feeding a one-entry output register with valid/ready handshakes on both sides.
module rr_stream_mux #(
    parameter int N_CH = 8,
    parameter int DW   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_stream_mux_if.slave  bus
);
    localparam int CW = $clog2(N_CH);

    logic [DW-1:0] ch_data [N_CH];

    logic          load;
    logic          grant_valid;
    logic [CW-1:0] grant_idx;

    logic [CW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [CW-1:0] out_ch_q, out_ch_d;
    logic          out_valid_q, out_valid_d;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign ch_data[gi] = bus.in_data[gi*DW +: DW];
            assign bus.in_ready[gi] = rst_n & load & grant_valid & (grant_idx == CW'(gi));
        end
    endgenerate

    assign load = ~out_valid_q | bus.out_ready;

    // Round-robin scan runs from the farthest offset to the nearest so the
    // channel closest to ptr is the one left standing.
    always_comb begin
        int            idx;
        logic [CW-1:0] idx_c;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_c       = '0;
        if (!bus.mode) begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.sel == CW'(i) && bus.in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = CW'(i);
                end
            end
        end else begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                idx = int'(ptr_q) + k;
                if (idx >= N_CH) begin
                    idx = idx - N_CH;
                end
                idx_c = CW'(idx);
                if (bus.in_valid[idx_c]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx_c;
                end
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load) begin
            if (grant_valid) begin
                out_data_d  = ch_data[grant_idx];
                out_ch_d    = grant_idx;
                out_valid_d = 1'b1;
                if (bus.mode) begin
                    ptr_d = (grant_idx == CW'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: stimulus pushes hand-computed output words into a
// scoreboard queue; a negedge monitor pops and compares each word the consumer accepts.
module tb_rr_stream_mux;
    logic clk;
    logic rst_n;

    rr_stream_mux_if #(.N_CH(8), .DW(8)) bus ();
    rr_stream_mux_if #(.N_CH(6), .DW(8)) b6 ();

    rr_stream_mux #(.N_CH(8), .DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rr_stream_mux #(.N_CH(6), .DW(8)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b6)
    );

    typedef struct {
        logic [2:0] ch;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #90000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", name, act, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int ch, input logic [7:0] data);
        exp_t e;
        e.ch   = 3'(ch);
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every word the consumer accepts must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got ch=%0d data=0x%0h, expected none at %0t",
                             bus.out_ch, bus.out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_ch", 64'(bus.out_ch), 64'(e.ch));
                    chk("out_data", 64'(bus.out_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        int rr_seq [4] = '{2, 6, 2, 6};

        rst_n         = 1'b0;
        bus.mode      = 1'b1;
        bus.sel       = '0;
        bus.in_valid  = 8'hFF;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) bus.in_data[i*8 +: 8] = 8'h10 + 8'(i);
        b6.mode       = 1'b0;
        b6.sel        = '0;
        b6.in_valid   = '0;
        b6.out_ready  = 1'b1;
        for (int i = 0; i < 6; i++) b6.in_data[i*8 +: 8] = 8'h20 + 8'(i);

        // Reset held two cycles with every channel valid
        cycle();
        cycle();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_ch", 64'(bus.out_ch), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);

        // Round-robin, all valid: ch0..7,0,1 back to back
        rst_n = 1'b1;
        #1;
        chk("rr_first_ready", 64'(bus.in_ready), 64'h01);
        push(0, 8'h10);
        for (int i = 1; i < 10; i++) begin
            cycle();
            chk("rr_all_ready", 64'(bus.in_ready), 64'(8'h01 << (i % 8)));
            push(i % 8, 8'h10 + 8'(i % 8));
        end
        cycle();
        bus.in_valid = 8'h00;
        cycle();
        chk("rr_drained", 64'(bus.out_valid), 64'd0);

        // Fixed select of ch5
        bus.mode = 1'b0;
        bus.sel = 3'd5;
        bus.in_data[40 +: 8] = 8'hA5;
        bus.in_valid = 8'hFF;
        #1;
        chk("fix_ready", 64'(bus.in_ready), 64'h20);
        push(5, 8'hA5);
        cycle();
        bus.in_valid = 8'h00;
        bus.in_data[40 +: 8] = 8'h15;
        cycle();

        // Six-channel instance: valid sel, then out-of-range sel
        b6.sel = 3'd3;
        b6.in_valid = 6'h3F;
        #1;
        chk("n6_ready_sel3", 64'(b6.in_ready), 64'h08);
        cycle();
        b6.sel = 3'd7;
        chk("n6_out_valid", 64'(b6.out_valid), 64'd1);
        chk("n6_out_ch", 64'(b6.out_ch), 64'd3);
        chk("n6_out_data", 64'(b6.out_data), 64'h23);
        #1;
        chk("n6_ready_sel7", 64'(b6.in_ready), 64'h00);
        cycle();
        chk("n6_sel7_valid", 64'(b6.out_valid), 64'd0);
        chk("n6_sel7_ch_hold", 64'(b6.out_ch), 64'd3);
        b6.in_valid = '0;

        // Sparse round-robin (ptr=2): ch2/ch6 alternate, then ch2 alone
        bus.mode = 1'b1;
        bus.in_valid = 8'h44;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_sparse_ready", 64'(bus.in_ready), 64'(8'h01 << rr_seq[i]));
            push(rr_seq[i], 8'h10 + 8'(rr_seq[i]));
            cycle();
        end
        bus.in_valid = 8'h04;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rr_single_ready", 64'(bus.in_ready), 64'h04);
            push(2, 8'h12);
            cycle();
        end
        bus.in_valid = 8'h00;
        cycle();

        // Backpressure with ch3 held (ptr=3 -> 4)
        bus.in_valid = 8'h08;
        bus.out_ready = 1'b0;
        #1;
        chk("bp_load_ready", 64'(bus.in_ready), 64'h08);
        push(3, 8'h13);
        cycle();
        bus.in_valid = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_ready_low", 64'(bus.in_ready), 64'h00);
            chk("bp_hold_ch", 64'(bus.out_ch), 64'd3);
            chk("bp_hold_data", 64'(bus.out_data), 64'h13);
            cycle();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(bus.in_ready), 64'h10);
        push(4, 8'h14);
        cycle();

        // ch5 loads, consumer stalls, then reset discards it
        #1;
        chk("pre_rst_ready", 64'(bus.in_ready), 64'h20);
        cycle();
        bus.out_ready = 1'b0;
        chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        chk("pre_rst_ch", 64'(bus.out_ch), 64'd5);
        rst_n = 1'b0;
        cycle();
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_ch", 64'(bus.out_ch), 64'd0);
        chk("mid_rst_ready", 64'(bus.in_ready), 64'h00);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("post_rst_ready", 64'(bus.in_ready), 64'h01);
        push(0, 8'h10);
        cycle();
        bus.in_valid = 8'h00;
        cycle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel, DW-bit registered stream multiplexer. Successor to the fixed 8:1 combinational mux.
- Two modes: fixed select (sel) and fair round-robin arbitration across valid channels.
- Uses valid/ready handshakes on all inputs and on the output, with a one-entry registered output stage.
- Sits between multiple producer streams and a single downstream consumer.

Parameters:
- N_CH, 8, number of input channels (>=2).
- DW, 8, data width per channel.
- CW, $clog2(N_CH), width of channel index and sel. Derived localparam; never overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  CW  channel index used when mode=0.
- in_data  input  N_CH*DW  packed channel data; channel i occupies bits [i*DW +: DW].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready; combinational, at most one bit set.
- out_data  output  DW  registered selected data.
- out_ch  output  CW  registered index of the channel that supplied out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
  - in_ready is 0 while rst_n=0, regardless of other inputs.
- Load condition: load = ~out_valid | out_ready. The output register accepts new data only when load=1.
- Grant, fixed mode (mode=0):
  - Grant goes to channel sel if sel<N_CH and in_valid[sel]=1.
  - sel>=N_CH gives no grant: all in_ready=0, and out_valid drops to 0 once drained.
- Grant, round-robin mode (mode=1):
  - Grant goes to the first channel with in_valid=1, scanning cyclically ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1.
  - If no channel is valid there is no grant.
- in_ready[g] = load & grant_valid for the granted channel g. All other bits are 0.
- in_ready may depend combinationally on in_valid, mode, sel and out_ready. It never depends combinationally on in_data.
- On a clk edge with load=1 and a grant:
  - out_data <= in_data[g], out_ch <= g, out_valid <= 1.
  - If mode=1, ptr <= (g+1) mod N_CH, wrapping N_CH-1 -> 0.
- On a clk edge with load=1 and no grant: out_valid <= 0. out_data and out_ch hold.
- With load=0 (out_valid=1, out_ready=0): all outputs hold, ptr holds, in_ready=0.
- Latency and throughput:
  - One cycle from an input handshake to out_valid.
  - Full throughput: one transfer per cycle when out_ready stays 1.
- Simultaneous drain and fill: out_valid=1 with out_ready=1 plus a grant loads the new word in the same edge, with no bubble.
- Mode switching:
  - mode is sampled every cycle.
  - ptr is never modified in fixed mode.
  - On return to mode=1, arbitration resumes from the retained ptr.
- A transfer is counted only on in_valid[i] & in_ready[i]. Producers must hold data stable while valid and not ready.
- Reset mid-operation: an in-flight output word is discarded (out_valid=0) and ptr returns to 0 on the same edge.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with in_valid=8'hFF, mode=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. After release, the first grant is ch0.
2. Fixed mode: mode=0, sel=5, in_data[5]=8'hA5, in_valid=8'hFF, out_ready=1 -> in_ready=8'b0010_0000. Next cycle out_data=8'hA5, out_ch=5, out_valid=1. Also with N_CH=6, sel=7 -> in_ready=0 and out_valid=0.
3. Round-robin, all valid, out_ready held 1, in_data[i]=8'h10+i -> out_ch sequence 0,1,...,7,0,1 on consecutive cycles, with out_data=8'h10..8'h17 and no gaps.
4. Round-robin, sparse: only ch2 and ch6 valid -> out_ch alternates 2,6,2,6. Then drop ch6 -> 2,2,2.
5. Backpressure: out_valid=1 with out_ch=3, out_ready=0 for 4 cycles -> out_data/out_ch held, in_ready=0, ptr=4 unchanged. Release with all valid -> next out_ch=4.
6. Reset mid-stream: after a grant to ch5 (ptr=6), assert rst_n=0 for one cycle with out_valid=1 -> out_valid=0. With all valid afterwards, the next out_ch=0.
